// File: rtl/checkout_tally_pkg.sv
// Shared types and tables for the checkout tally stage: FSM states, UPC validity mask, price table.
// Prices are used only when the running-total option is built in.
package checkout_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  // Bit n set means UPC code n is a valid product; 010 and 111 are not.
  localparam logic [7:0] UPC_VALID = 8'b0111_1011;

  localparam logic [7:0] PRICE [0:7] = '{
    8'd10, 8'd25, 8'd0, 8'd99, 8'd40, 8'd55, 8'd70, 8'd0
  };

endpackage

// File: rtl/checkout_tally_if.sv
// Scan-side inputs and tally-side outputs of checkout_tally; master drives the switches/key,
// slave is the tally. CHECKOUT_TOTAL_EN adds the 12-bit running total.
interface checkout_tally_if #(
  parameter int COUNT_W = 4
);
  logic               scan_key_n;
  logic [2:0]         upc;
  logic               discounted;
  logic               stolen;
  logic               clear;
  logic [COUNT_W-1:0] item_count;
  logic [COUNT_W-1:0] disc_count;
  logic [COUNT_W-1:0] stolen_count;
  logic               scan_ack;
  logic               scan_err;
  logic               alarm;
  logic               full;
`ifdef CHECKOUT_TOTAL_EN
  logic [11:0]        total;
`endif

  modport master (
    output scan_key_n, upc, discounted, stolen, clear,
    input  item_count, disc_count, stolen_count, scan_ack, scan_err, alarm, full
`ifdef CHECKOUT_TOTAL_EN
    , input total
`endif
  );

  modport slave (
    input  scan_key_n, upc, discounted, stolen, clear,
    output item_count, disc_count, stolen_count, scan_ack, scan_err, alarm, full
`ifdef CHECKOUT_TOTAL_EN
    , output total
`endif
  );

endinterface

// File: rtl/checkout_tally_key_edge_sync.sv
// Two-flop synchroniser for the raw active-low key plus a one-cycle pulse on the synced 1->0 edge.
// Pulse appears 2 cycles after the pin falls; holding the key gives exactly one pulse.
module key_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic meta;
  logic sync;
  logic prev;

  // All stages reset to 1 so a released key never looks like a press out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= key_n;
      sync <= meta;
      prev <= sync;
    end
  end

  assign press = prev & ~sync;

endmodule

// File: rtl/checkout_tally.sv
// Per-customer item/discount/stolen tallies with a timed stolen-item alarm; pin-to-output 3 cycles,
// no backpressure (scans during ALARM are dropped). CHECKOUT_TOTAL_EN adds a saturating price total.
module checkout_tally
  import checkout_pkg::*;
#(
  parameter int COUNT_W      = 4,
  parameter int ALARM_CYCLES = 8
) (
  input logic              clk,
  input logic              reset_n,
  checkout_tally_if.slave  bus
);

  localparam int TIMER_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  logic               press;
  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [COUNT_W-1:0] item_count;
  logic [COUNT_W-1:0] disc_count;
  logic [COUNT_W-1:0] stolen_count;
  logic               scan_ack;
  logic               scan_err;
  logic               alarm;
  logic               full;

  key_edge_sync u_key_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (bus.scan_key_n),
    .press   (press)
  );

  assign full = (item_count == {COUNT_W{1'b1}});

`ifdef CHECKOUT_TOTAL_EN
  logic [11:0] total;
  logic [7:0]  price;
  logic [7:0]  charge;
  logic [12:0] total_sum;

  always_comb begin
    price     = PRICE[bus.upc];
    charge    = bus.discounted ? {1'b0, price[7:1]} : price;
    total_sum = {1'b0, total} + {5'd0, charge};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      total <= 12'd0;
    end else if (state == IDLE && press && UPC_VALID[bus.upc] && !bus.stolen && !full) begin
      total <= total_sum[12] ? 12'hFFF : total_sum[11:0];
    end
  end

  assign bus.total = total;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      item_count   <= '0;
      disc_count   <= '0;
      stolen_count <= '0;
      scan_ack     <= 1'b0;
      scan_err     <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      scan_ack <= 1'b0;
      scan_err <= 1'b0;
      if (bus.clear) begin
        // Clear beats a coincident scan: the event is dropped with no pulse.
        state        <= IDLE;
        timer        <= '0;
        item_count   <= '0;
        disc_count   <= '0;
        stolen_count <= '0;
        alarm        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              if (!UPC_VALID[bus.upc]) begin
                scan_err <= 1'b1;
              end else if (bus.stolen) begin
                if (stolen_count != {COUNT_W{1'b1}}) begin
                  stolen_count <= stolen_count + 1'b1;
                end
                scan_ack <= 1'b1;
                timer    <= TIMER_W'(ALARM_CYCLES - 1);
                alarm    <= 1'b1;
                state    <= ALARM;
              end else if (full) begin
                scan_err <= 1'b1;
              end else begin
                item_count <= item_count + 1'b1;
                if (bus.discounted) begin
                  disc_count <= disc_count + 1'b1;
                end
                scan_ack <= 1'b1;
              end
            end
          end
          ALARM: begin
            if (timer == '0) begin
              alarm <= 1'b0;
              state <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.item_count   = item_count;
  assign bus.disc_count   = disc_count;
  assign bus.stolen_count = stolen_count;
  assign bus.scan_ack     = scan_ack;
  assign bus.scan_err     = scan_err;
  assign bus.alarm        = alarm;
  assign bus.full         = full;

endmodule
